pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline.
- Generates hold enables for PC, IF/ID and the ID/EX bubble request from register-use timing (Tuse/Tnew).
- Tracks multiply/divide unit occupancy with an internal countdown FSM.
- Turns an exception/interrupt request at M into a pipeline-wide flush.
- Sits beside the decode stage; drives enable/flush of every pipeline register.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_mdu_busy_tracker.sv | 66 ++++++
 rtl/pipe_hazard_ctrl.sv | 85 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: Tuse/Tnew markers,
// default MDU latencies and the MDU occupancy FSM state codes.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_ZERO = 2'd0;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_busy_tracker.sv
// Multiply/divide occupancy tracker: a two-state FSM with a countdown that
// reports the MDU busy from its start cycle until the latency has elapsed.
module mdu_busy_tracker
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             flush,
    output logic             busy,
    output mdu_state_t       state,
    output logic [CNT_W-1:0] cnt
);

    mdu_state_t       state_n;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] load_val;

    assign load_val = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MDU_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // A start that coincides with a flush belongs to the flushed E instr.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            MDU_IDLE: begin
                if (start && !flush) begin
                    state_n = MDU_BUSY;
                    cnt_n   = load_val;
                end
            end
            MDU_BUSY: begin
                if (start && !flush) begin
                    cnt_n = load_val;
                end else if (cnt == CNT_W'(1)) begin
                    state_n = MDU_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_n = MDU_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign busy = (state == MDU_BUSY) | start;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: register-use, MDU and eret hazards produce
// a decode stall; an exception at M flushes the pipeline and overrides stalls.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_TuseRs,
    input  logic [1:0] D_TuseRt,
    input  logic       D_isMdu,
    input  logic       D_isEret,
    input  logic [4:0] E_A3,
    input  logic [1:0] E_Tnew,
    input  logic       E_mduStart,
    input  logic       E_mduIsDiv,
    input  logic       E_mtc0Epc,
    input  logic [4:0] M_A3,
    input  logic [1:0] M_Tnew,
    input  logic       M_mtc0Epc,
    input  logic       M_req,
    output logic       pc_enable,
    output logic       FD_enable,
    output logic       DE_enable,
    output logic       DE_flush,
    output logic       EM_flush,
    output logic       MW_flush,
    output logic       mdu_busy
);

    mdu_state_t       mdu_state;
    logic [CNT_W-1:0] mdu_cnt;

    logic stall_rs, stall_rt, stall_mdu, stall_eret, stall;

    mdu_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_mdu (
        .clk    (clk),
        .reset  (reset),
        .start  (E_mduStart),
        .is_div (E_mduIsDiv),
        .flush  (M_req),
        .busy   (mdu_busy),
        .state  (mdu_state),
        .cnt    (mdu_cnt)
    );

    // A producer stalls a consumer only while its result arrives later than needed;
    // Tuse = TUSE_NONE can never be exceeded by a 2-bit Tnew.
    assign stall_rs = (D_rs != 5'd0) &
                      (((D_rs == E_A3) & (E_Tnew > D_TuseRs)) |
                       ((D_rs == M_A3) & (M_Tnew > D_TuseRs)));
    assign stall_rt = (D_rt != 5'd0) &
                      (((D_rt == E_A3) & (E_Tnew > D_TuseRt)) |
                       ((D_rt == M_A3) & (M_Tnew > D_TuseRt)));

    assign stall_mdu  = D_isMdu & mdu_busy;
    assign stall_eret = D_isEret & (E_mtc0Epc | M_mtc0Epc);
    assign stall      = stall_rs | stall_rt | stall_mdu | stall_eret;

    always_comb begin
        pc_enable = ~stall;
        FD_enable = ~stall;
        DE_enable = 1'b1;
        DE_flush  = stall;
        EM_flush  = 1'b0;
        MW_flush  = 1'b0;
        if (M_req) begin
            pc_enable = 1'b1;
            FD_enable = 1'b1;
            DE_flush  = 1'b1;
            EM_flush  = 1'b1;
            MW_flush  = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs change and outputs are checked
// on the falling edge, expectations are hand-computed output vectors.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_A3, M_A3;
    logic [1:0] D_TuseRs, D_TuseRt, E_Tnew, M_Tnew;
    logic       D_isMdu, D_isEret, E_mduStart, E_mduIsDiv, E_mtc0Epc, M_mtc0Epc, M_req;
    logic       pc_enable, FD_enable, DE_enable, DE_flush, EM_flush, MW_flush, mdu_busy;

    int errors = 0;
    int checks = 0;

    // {pc_enable, FD_enable, DE_enable, DE_flush, EM_flush, MW_flush, mdu_busy}
    localparam logic [6:0] NORM  = 7'b111_000_0;
    localparam logic [6:0] STALL = 7'b001_100_0;
    localparam logic [6:0] FLUSH = 7'b111_111_0;
    localparam logic [6:0] BUSY  = 7'b000_000_1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_TuseRs   (D_TuseRs),
        .D_TuseRt   (D_TuseRt),
        .D_isMdu    (D_isMdu),
        .D_isEret   (D_isEret),
        .E_A3       (E_A3),
        .E_Tnew     (E_Tnew),
        .E_mduStart (E_mduStart),
        .E_mduIsDiv (E_mduIsDiv),
        .E_mtc0Epc  (E_mtc0Epc),
        .M_A3       (M_A3),
        .M_Tnew     (M_Tnew),
        .M_mtc0Epc  (M_mtc0Epc),
        .M_req      (M_req),
        .pc_enable  (pc_enable),
        .FD_enable  (FD_enable),
        .DE_enable  (DE_enable),
        .DE_flush   (DE_flush),
        .EM_flush   (EM_flush),
        .MW_flush   (MW_flush),
        .mdu_busy   (mdu_busy)
    );

    task automatic clear_inputs();
        D_rs = 5'd0; D_rt = 5'd0; D_TuseRs = 2'd3; D_TuseRt = 2'd3;
        D_isMdu = 1'b0; D_isEret = 1'b0;
        E_A3 = 5'd0; E_Tnew = 2'd0; E_mduStart = 1'b0; E_mduIsDiv = 1'b0; E_mtc0Epc = 1'b0;
        M_A3 = 5'd0; M_Tnew = 2'd0; M_mtc0Epc = 1'b0; M_req = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [6:0] expected);
        logic [6:0] observed;
        #1;
        observed = {pc_enable, FD_enable, DE_enable, DE_flush, EM_flush, MW_flush, mdu_busy};
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        check("reset_idle", NORM);

        // load-use: lw $1 in E, addu reads $1 next
        next_cycle();
        D_rs = 5'd1; D_TuseRs = 2'd1; E_A3 = 5'd1; E_Tnew = 2'd2;
        check("load_use_e", STALL);
        next_cycle();
        E_A3 = 5'd0; E_Tnew = 2'd0; M_A3 = 5'd1; M_Tnew = 2'd1;
        check("load_use_m_released", NORM);

        // rt path against M, Tnew one above Tuse
        next_cycle();
        clear_inputs();
        D_rt = 5'd2; D_TuseRt = 2'd0; M_A3 = 5'd2; M_Tnew = 2'd1;
        check("rt_m_stall", STALL);

        // Tnew of zero never stalls
        next_cycle();
        clear_inputs();
        D_rs = 5'd7; D_TuseRs = 2'd0; E_A3 = 5'd7; E_Tnew = 2'd0;
        check("tnew_zero", NORM);

        // register zero never stalls
        next_cycle();
        clear_inputs();
        D_rs = 5'd0; D_TuseRs = 2'd0; E_A3 = 5'd0; E_Tnew = 2'd2;
        check("reg_zero", NORM);

        // div occupancy: start cycle plus 10
        next_cycle();
        clear_inputs();
        E_mduStart = 1'b1; E_mduIsDiv = 1'b1; D_isMdu = 1'b1;
        check("div_start", STALL | BUSY);
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            E_mduStart = 1'b0; E_mduIsDiv = 1'b0;
            check($sformatf("div_busy_%0d", i), STALL | BUSY);
        end
        next_cycle();
        check("div_release", NORM);

        // mult occupancy: start cycle plus 5
        next_cycle();
        E_mduStart = 1'b1;
        check("mult_start", STALL | BUSY);
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            E_mduStart = 1'b0;
            check($sformatf("mult_busy_%0d", i), STALL | BUSY);
        end
        next_cycle();
        check("mult_release", NORM);

        // start cancelled by a same-cycle exception
        next_cycle();
        clear_inputs();
        E_mduStart = 1'b1; E_mduIsDiv = 1'b1; M_req = 1'b1;
        check("start_with_req", FLUSH | BUSY);
        next_cycle();
        clear_inputs();
        D_isMdu = 1'b1;
        check("start_cancelled", NORM);

        // exception overrides a register stall
        next_cycle();
        clear_inputs();
        D_rs = 5'd3; D_TuseRs = 2'd0; E_A3 = 5'd3; E_Tnew = 2'd2; M_req = 1'b1;
        check("req_over_stall", FLUSH);

        // eret behind mtc0 EPC in M: one cycle
        next_cycle();
        clear_inputs();
        D_isEret = 1'b1; M_mtc0Epc = 1'b1;
        check("eret_m", STALL);
        next_cycle();
        M_mtc0Epc = 1'b0;
        check("eret_m_release", NORM);

        // eret behind mtc0 EPC in E: two cycles while it advances
        next_cycle();
        E_mtc0Epc = 1'b1;
        check("eret_e", STALL);
        next_cycle();
        E_mtc0Epc = 1'b0; M_mtc0Epc = 1'b1;
        check("eret_e_to_m", STALL);
        next_cycle();
        M_mtc0Epc = 1'b0;
        check("eret_e_release", NORM);

        // exception while busy: older MDU op keeps counting
        next_cycle();
        clear_inputs();
        E_mduStart = 1'b1;
        check("mult2_start", NORM | BUSY);
        next_cycle();
        E_mduStart = 1'b0; M_req = 1'b1;
        check("mult2_req_busy", FLUSH | BUSY);
        for (int i = 2; i <= 5; i++) begin
            next_cycle();
            M_req = 1'b0;
            check($sformatf("mult2_busy_%0d", i), NORM | BUSY);
        end
        next_cycle();
        check("mult2_release", NORM);

        // reset in the middle of a divide
        next_cycle();
        E_mduStart = 1'b1; E_mduIsDiv = 1'b1;
        check("div2_start", NORM | BUSY);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            E_mduStart = 1'b0; E_mduIsDiv = 1'b0;
            check($sformatf("div2_busy_%0d", i), NORM | BUSY);
        end
        next_cycle();
        reset = 1'b1;
        check("div2_reset_cycle", NORM | BUSY);
        next_cycle();
        reset = 1'b0;
        D_isMdu = 1'b1;
        check("div2_after_reset", NORM);
        next_cycle();
        check("div2_after_reset_2", NORM);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
